// File: rtl/data_island_if.sv
// Handshake bundle between the data-island scheduler and its neighbours.
// The master side is the audio FIFO and packet assembler. The slave side is the scheduler.
interface data_island_if;
   logic       frame_start;
   logic       acr_tick;
   logic [2:0] audio_count;
   logic       slot_req;
   logic       packet_done;
   logic       grant_valid;
   logic [7:0] grant_type;
   logic [2:0] grant_samples;
   logic       audio_pop;
   logic       audio_overrun;
   logic       protocol_err;

   modport master (
      output frame_start, acr_tick, audio_count, slot_req, packet_done,
      input  grant_valid, grant_type, grant_samples, audio_pop, audio_overrun, protocol_err
   );
   modport slave (
      input  frame_start, acr_tick, audio_count, slot_req, packet_done,
      output grant_valid, grant_type, grant_samples, audio_pop, audio_overrun, protocol_err
   );
endinterface

// File: rtl/data_island_scheduler.sv
// Chooses the packet for each HDMI data-island slot: ACR, audio, round-robin InfoFrames, or null.
// Define HDMI_SPD_INFOFRAME_EN to add the SPD InfoFrame to the rotation.
module data_island_scheduler #(
   parameter int INFOFRAME_PERIOD = 1,
   parameter int AUDIO_URGENT     = 5,
   parameter int MAX_SAMPLES      = 4
) (
   input logic         clk_pixel,
   input logic         reset_n,
   data_island_if.slave bus
);
`ifdef HDMI_SPD_INFOFRAME_EN
   localparam int NUM_IF = 3;
`else
   localparam int NUM_IF = 2;
`endif
   localparam logic [2:0] IF_MASK = (NUM_IF == 3) ? 3'b111 : 3'b011;

   typedef enum logic [1:0] {IDLE, ARB, BUSY} state_t;

   state_t     state_q, state_d;
   logic       acr_pend_q, acr_pend_d, acr_snap_q, acr_snap_d;
   logic [2:0] if_pend_q, if_pend_d, if_snap_q, if_snap_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic [1:0] rr_ptr_q, rr_ptr_d;
   logic       grant_valid_q, grant_valid_d;
   logic [7:0] grant_type_q, grant_type_d;
   logic [2:0] grant_samples_q, grant_samples_d;
   logic       audio_pop_q, audio_pop_d;
   logic       overrun_q, overrun_d;
   logic       proto_err_q, proto_err_d;

   logic       acr_clr, if_found, urgent, have_audio;
   logic [2:0] if_clr, if_set, cand, samples;
   logic [1:0] if_pick, rr_next;
   logic [7:0] if_type;

   always_comb begin
      if_found = 1'b0;
      if_pick  = 2'd0;
      cand     = 3'd0;
      // First pending InfoFrame at or after rr_ptr, wrapping over the enabled entries.
      for (int i = 0; i < 3; i++) begin
         cand = {1'b0, rr_ptr_q} + 3'(i);
         if (cand >= 3'(NUM_IF)) cand = cand - 3'(NUM_IF);
         if (i < NUM_IF && !if_found && if_snap_q[cand[1:0]]) begin
            if_found = 1'b1;
            if_pick  = cand[1:0];
         end
      end
      rr_next = (if_pick == 2'(NUM_IF - 1)) ? 2'd0 : if_pick + 2'd1;
      case (if_pick)
         2'd0:    if_type = 8'h82;
         2'd1:    if_type = 8'h84;
         default: if_type = 8'h83;
      endcase
   end

   always_comb begin
      urgent     = bus.audio_count >= 3'(AUDIO_URGENT);
      have_audio = bus.audio_count != 3'd0;
      samples    = (bus.audio_count > 3'(MAX_SAMPLES)) ? 3'(MAX_SAMPLES) : bus.audio_count;

      state_d         = state_q;
      acr_snap_d      = acr_snap_q;
      if_snap_d       = if_snap_q;
      rr_ptr_d        = rr_ptr_q;
      grant_valid_d   = grant_valid_q;
      grant_type_d    = grant_type_q;
      grant_samples_d = grant_samples_q;
      audio_pop_d     = 1'b0;
      acr_clr         = 1'b0;
      if_clr          = 3'b000;
      if_set          = 3'b000;
      frame_cnt_d     = frame_cnt_q;

      case (state_q)
         IDLE: if (bus.slot_req) begin
            // Snapshot so events landing with slot_req wait for the next arbitration.
            state_d    = ARB;
            acr_snap_d = acr_pend_q;
            if_snap_d  = if_pend_q;
         end
         ARB: begin
            state_d         = BUSY;
            grant_valid_d   = 1'b1;
            grant_samples_d = 3'd0;
            if (urgent || (!acr_snap_q && have_audio)) begin
               grant_type_d    = 8'h02;
               grant_samples_d = samples;
               audio_pop_d     = 1'b1;
            end else if (acr_snap_q) begin
               grant_type_d = 8'h01;
               acr_clr      = 1'b1;
            end else if (if_found) begin
               grant_type_d    = if_type;
               if_clr[if_pick] = 1'b1;
               rr_ptr_d        = rr_next;
            end else begin
               grant_type_d = 8'h00;
            end
         end
         BUSY: if (bus.packet_done) begin
            state_d         = IDLE;
            grant_valid_d   = 1'b0;
            grant_type_d    = 8'h00;
            grant_samples_d = 3'd0;
         end
         default: state_d = IDLE;
      endcase

      if (bus.frame_start) begin
         if (frame_cnt_q == 8'(INFOFRAME_PERIOD - 1)) begin
            frame_cnt_d = 8'd0;
            if_set      = IF_MASK;
         end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
         end
      end

      acr_pend_d  = (acr_pend_q & ~acr_clr) | bus.acr_tick;
      if_pend_d   = (if_pend_q & ~if_clr) | if_set;
      overrun_d   = overrun_q | (bus.audio_count == 3'd7);
      proto_err_d = proto_err_q | (bus.slot_req && state_q != IDLE);
   end

   always_ff @(posedge clk_pixel) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         acr_pend_q      <= 1'b0;
         acr_snap_q      <= 1'b0;
         if_pend_q       <= 3'b000;
         if_snap_q       <= 3'b000;
         frame_cnt_q     <= 8'd0;
         rr_ptr_q        <= 2'd0;
         grant_valid_q   <= 1'b0;
         grant_type_q    <= 8'h00;
         grant_samples_q <= 3'd0;
         audio_pop_q     <= 1'b0;
         overrun_q       <= 1'b0;
         proto_err_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         acr_pend_q      <= acr_pend_d;
         acr_snap_q      <= acr_snap_d;
         if_pend_q       <= if_pend_d;
         if_snap_q       <= if_snap_d;
         frame_cnt_q     <= frame_cnt_d;
         rr_ptr_q        <= rr_ptr_d;
         grant_valid_q   <= grant_valid_d;
         grant_type_q    <= grant_type_d;
         grant_samples_q <= grant_samples_d;
         audio_pop_q     <= audio_pop_d;
         overrun_q       <= overrun_d;
         proto_err_q     <= proto_err_d;
      end
   end

   assign bus.grant_valid   = grant_valid_q;
   assign bus.grant_type    = grant_type_q;
   assign bus.grant_samples = grant_samples_q;
   assign bus.audio_pop     = audio_pop_q;
   assign bus.audio_overrun = overrun_q;
   assign bus.protocol_err  = proto_err_q;
endmodule

// File: tb/tb_data_island_scheduler.sv
// Scoreboard bench for data_island_scheduler: one instance with INFOFRAME_PERIOD=1 and one with 3.
module tb_data_island_scheduler;
   logic clk_pixel = 1'b0;
   logic reset_n;
   always #5 clk_pixel = ~clk_pixel;

   data_island_if i1 ();
   data_island_if i3 ();

   data_island_scheduler #(.INFOFRAME_PERIOD(1), .AUDIO_URGENT(5), .MAX_SAMPLES(4)) dut (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .bus(i1));
   data_island_scheduler #(.INFOFRAME_PERIOD(3), .AUDIO_URGENT(5), .MAX_SAMPLES(4)) dut3 (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .bus(i3));

`ifdef HDMI_SPD_INFOFRAME_EN
   localparam logic [7:0] THIRD_IF = 8'h83;
`else
   localparam logic [7:0] THIRD_IF = 8'h00;
`endif

   typedef struct {
      logic [7:0] t;
      logic [2:0] s;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic prev_gv = 1'b0;

   always @(posedge clk_pixel) cyc <= cyc + 1;

   // Scoreboard monitor: every rising grant_valid must match the oldest expected grant.
   always @(negedge clk_pixel) begin
      if (i1.grant_valid === 1'b1 && prev_gv !== 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_grant type=%h", i1.grant_type);
         end else begin
            e = sb.pop_front();
            if (i1.grant_type !== e.t) begin
               bad++; $display("FAIL grant_type got=%h exp=%h", i1.grant_type, e.t);
            end
            total++;
            if (i1.grant_samples !== e.s) begin
               bad++; $display("FAIL grant_samples got=%0d exp=%0d", i1.grant_samples, e.s);
            end
            total++;
            if (i1.audio_pop !== (e.s != 3'd0)) begin
               bad++; $display("FAIL audio_pop got=%b exp=%b", i1.audio_pop, e.s != 3'd0);
            end
            total++;
            if (cyc !== e.cyc) begin
               bad++; $display("FAIL grant_latency got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
            end
         end
      end else if (reset_n === 1'b1) begin
         total++;
         if (i1.audio_pop !== 1'b0) begin
            bad++; $display("FAIL audio_pop_extra got=%b exp=0", i1.audio_pop);
         end
      end
      prev_gv = i1.grant_valid;
   end

   task automatic req(input logic [7:0] t, input logic [2:0] s, input bit with_acr);
      @(negedge clk_pixel);
      i1.slot_req = 1'b1;
      i1.acr_tick = with_acr;
      sb.push_back('{t, s, cyc + 2});
      @(negedge clk_pixel);
      i1.slot_req = 1'b0;
      i1.acr_tick = 1'b0;
   endtask

   task automatic wait_grant();
      int n = 0;
      while (i1.grant_valid !== 1'b1 && n < 10) begin
         @(negedge clk_pixel);
         n++;
      end
      total++;
      if (i1.grant_valid !== 1'b1) begin
         bad++; $display("FAIL grant_timeout got=%b exp=1", i1.grant_valid);
      end
      @(negedge clk_pixel);
      i1.packet_done = 1'b1;
      @(negedge clk_pixel);
      i1.packet_done = 1'b0;
      total++;
      if (i1.grant_valid !== 1'b0) begin
         bad++; $display("FAIL grant_release got=%b exp=0", i1.grant_valid);
      end
   endtask

   task automatic pulse_acr();
      @(negedge clk_pixel); i1.acr_tick = 1'b1;
      @(negedge clk_pixel); i1.acr_tick = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      i1.slot_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_pixel);
         total++;
         if ({i1.grant_valid, i1.grant_type, i1.grant_samples, i1.audio_pop,
              i1.audio_overrun, i1.protocol_err} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs gv=%b type=%h smp=%0d pop=%b ovr=%b err=%b exp=all0",
                     i1.grant_valid, i1.grant_type, i1.grant_samples, i1.audio_pop,
                     i1.audio_overrun, i1.protocol_err);
         end
      end
      reset_n = 1'b1;
      i1.slot_req = 1'b0;
      repeat (4) @(negedge clk_pixel);
      total++;
      if (i1.grant_valid !== 1'b0) begin
         bad++; $display("FAIL reset_no_grant got=%b exp=0", i1.grant_valid);
      end
   endtask

   task automatic test_acr_then_audio();
      i1.audio_count = 3'd2;
      pulse_acr();
      req(8'h01, 3'd0, 1'b0); wait_grant();
      req(8'h02, 3'd2, 1'b0); wait_grant();
      i1.audio_count = 3'd0;
   endtask

   task automatic test_urgent_audio();
      i1.audio_count = 3'd6;
      pulse_acr();
      req(8'h02, 3'd4, 1'b0); wait_grant();
      i1.audio_count = 3'd0;
      req(8'h01, 3'd0, 1'b0); wait_grant();
   endtask

   task automatic test_infoframe_rr();
      @(negedge clk_pixel); i1.frame_start = 1'b1;
      @(negedge clk_pixel); i1.frame_start = 1'b0;
      req(8'h82, 3'd0, 1'b0);   wait_grant();
      req(8'h84, 3'd0, 1'b0);   wait_grant();
      req(THIRD_IF, 3'd0, 1'b0); wait_grant();
      req(8'h00, 3'd0, 1'b0);   wait_grant();
   endtask

   task automatic test_reset_mid();
      i1.audio_count = 3'd3;
      @(negedge clk_pixel); i1.slot_req = 1'b1;
      @(negedge clk_pixel); i1.slot_req = 1'b0; reset_n = 1'b0;
      @(negedge clk_pixel);
      total++;
      if ({i1.grant_valid, i1.audio_pop, i1.grant_type} !== 10'd0) begin
         bad++; $display("FAIL reset_mid gv=%b pop=%b type=%h exp=0", i1.grant_valid,
                         i1.audio_pop, i1.grant_type);
      end
      reset_n = 1'b1;
      i1.audio_count = 3'd0;
      repeat (3) @(negedge clk_pixel);
   endtask

   task automatic test_acr_collide();
      req(8'h00, 3'd0, 1'b1); wait_grant();
      req(8'h01, 3'd0, 1'b0);
      i1.acr_tick = 1'b1;
      @(negedge clk_pixel); i1.acr_tick = 1'b0;
      wait_grant();
      req(8'h01, 3'd0, 1'b0); wait_grant();
      req(8'h00, 3'd0, 1'b0); wait_grant();
   endtask

   task automatic test_protocol_overrun();
      total++;
      if (i1.protocol_err !== 1'b0) begin
         bad++; $display("FAIL protocol_err_pre got=%b exp=0", i1.protocol_err);
      end
      req(8'h00, 3'd0, 1'b0);
      @(negedge clk_pixel); i1.slot_req = 1'b1;
      @(negedge clk_pixel); i1.slot_req = 1'b0;
      total++;
      if ({i1.protocol_err, i1.grant_valid, i1.grant_type} !== {1'b1, 1'b1, 8'h00}) begin
         bad++; $display("FAIL protocol_err err=%b gv=%b type=%h exp=1,1,00",
                         i1.protocol_err, i1.grant_valid, i1.grant_type);
      end
      wait_grant();
      repeat (3) @(negedge clk_pixel);
      total++;
      if (i1.audio_overrun !== 1'b0) begin
         bad++; $display("FAIL overrun_pre got=%b exp=0", i1.audio_overrun);
      end
      i1.audio_count = 3'd7;
      @(negedge clk_pixel); i1.audio_count = 3'd0;
      repeat (3) @(negedge clk_pixel);
      total++;
      if ({i1.audio_overrun, i1.protocol_err} !== 2'b11) begin
         bad++; $display("FAIL sticky_flags ovr=%b err=%b exp=1,1", i1.audio_overrun,
                         i1.protocol_err);
      end
   endtask

   task automatic slot3(input logic [7:0] t, input string name);
      @(negedge clk_pixel); i3.slot_req = 1'b1;
      @(negedge clk_pixel); i3.slot_req = 1'b0;
      @(negedge clk_pixel);
      total++;
      if ({i3.grant_valid, i3.grant_type} !== {1'b1, t}) begin
         bad++; $display("FAIL %s gv=%b type=%h exp=1,%h", name, i3.grant_valid, i3.grant_type, t);
      end
      i3.packet_done = 1'b1;
      @(negedge clk_pixel); i3.packet_done = 1'b0;
   endtask

   task automatic test_period3();
      for (int f = 0; f < 2; f++) begin
         @(negedge clk_pixel); i3.frame_start = 1'b1;
         @(negedge clk_pixel); i3.frame_start = 1'b0;
      end
      slot3(8'h00, "period3_before_wrap");
      @(negedge clk_pixel); i3.frame_start = 1'b1;
      @(negedge clk_pixel); i3.frame_start = 1'b0;
      slot3(8'h82, "period3_wrap");
   endtask

   initial begin
      i1.frame_start = 1'b0; i1.acr_tick = 1'b0; i1.audio_count = 3'd0;
      i1.slot_req = 1'b0; i1.packet_done = 1'b0;
      i3.frame_start = 1'b0; i3.acr_tick = 1'b0; i3.audio_count = 3'd0;
      i3.slot_req = 1'b0; i3.packet_done = 1'b0;
      reset_n = 1'b0;
      test_reset();
      test_acr_then_audio();
      test_urgent_audio();
      test_infoframe_rr();
      test_reset_mid();
      test_acr_collide();
      test_protocol_overrun();
      test_period3();
      repeat (3) @(negedge clk_pixel);
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
